// File: rtl/gen_meter.sv
// Window measurement on a signed sample stream: peak |x|, mean |x| and positive-going zero crossings.
// Optional DC mean accumulator is built when GEN_METER_DC_EN is defined; otherwise dc_mean is tied to 0.
module gen_meter #(
    parameter int unsigned DW       = 18,
    parameter int unsigned LOG2_MAX = 24
) (
    input  logic                adc_clk,
    input  logic                reset,
    input  logic [DW-1:0]       in_data,
    input  logic                in_valid,
    input  logic                start,
    input  logic [4:0]          win_log2,
    output logic                busy,
    output logic                done,
    output logic [DW-1:0]       peak,
    output logic [DW-1:0]       mean_mag,
    output logic [LOG2_MAX-1:0] zc_count,
    output logic [DW-1:0]       dc_mean
);

    localparam int unsigned AW   = DW + LOG2_MAX;
    localparam int unsigned CW   = LOG2_MAX;
    localparam logic [4:0]  NMAX = 5'(LOG2_MAX);

    typedef enum logic [1:0] {IDLE, RUN, LATCH} state_t;

    state_t         state;
    state_t         state_nx;
    logic           win_clr;
    logic           acc_en;
    logic           ld_en;
    logic           busy_nx;
    logic           done_nx;

    logic [4:0]     n_c;
    logic [CW:0]    one_sh;
    logic [CW-1:0]  mask_c;
    logic [DW-1:0]  abs_c;

    logic [4:0]     n_r;
    logic [CW-1:0]  mask_r;
    logic [CW-1:0]  cnt;
    logic           win_full;
    logic           first;
    logic           prev_neg;
    logic [DW-1:0]  pk_acc;
    logic [AW-1:0]  mag_acc;
    logic [CW-1:0]  zc_acc;

    // State register
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; the window closes one cycle after its last sample lands
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (win_full) state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control decode per state
    always_comb begin
        win_clr = 1'b0;
        acc_en  = 1'b0;
        ld_en   = 1'b0;
        busy_nx = 1'b0;
        done_nx = 1'b0;
        case (state)
            IDLE: begin
                win_clr = start;
                busy_nx = start;
            end
            RUN: begin
                acc_en  = in_valid && !win_full;
                busy_nx = 1'b1;
            end
            LATCH: begin
                ld_en   = 1'b1;
                done_nx = 1'b1;
            end
            default: ;
        endcase
    end

    // Window exponent clamp and last-sample index (2^N - 1 fits the counter even at N = LOG2_MAX)
    always_comb begin
        if (win_log2 == 5'd0) begin
            n_c = 5'd1;
        end else if (win_log2 > NMAX) begin
            n_c = NMAX;
        end else begin
            n_c = win_log2;
        end
        one_sh = (CW+1)'(1) << n_c;
        mask_c = CW'(one_sh - (CW+1)'(1));
        abs_c  = in_data[DW-1] ? DW'(~in_data + DW'(1)) : in_data;
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            peak     <= '0;
            mean_mag <= '0;
            zc_count <= '0;
            n_r      <= 5'd1;
            mask_r   <= '0;
            cnt      <= '0;
            win_full <= 1'b0;
            first    <= 1'b1;
            prev_neg <= 1'b0;
            pk_acc   <= '0;
            mag_acc  <= '0;
            zc_acc   <= '0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
            if (win_clr) begin
                n_r      <= n_c;
                mask_r   <= mask_c;
                cnt      <= '0;
                win_full <= 1'b0;
                first    <= 1'b1;
                prev_neg <= 1'b0;
                pk_acc   <= '0;
                mag_acc  <= '0;
                zc_acc   <= '0;
            end else if (acc_en) begin
                pk_acc   <= (abs_c > pk_acc) ? abs_c : pk_acc;
                mag_acc  <= mag_acc + AW'(abs_c);
                cnt      <= cnt + CW'(1);
                first    <= 1'b0;
                prev_neg <= in_data[DW-1];
                if (!first && prev_neg && !in_data[DW-1]) begin
                    zc_acc <= zc_acc + CW'(1);
                end
                if (cnt == mask_r) begin
                    win_full <= 1'b1;
                end
            end
            // Normalising shift lives here so the accumulate path stays a single adder
            if (ld_en) begin
                peak     <= pk_acc;
                mean_mag <= DW'(mag_acc >> n_r);
                zc_count <= zc_acc;
            end
        end
    end

`ifdef GEN_METER_DC_EN
    logic signed [AW-1:0] dc_acc;

    // Signed sum of raw samples for the DC estimate
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            dc_acc  <= '0;
            dc_mean <= '0;
        end else begin
            if (win_clr) begin
                dc_acc <= '0;
            end else if (acc_en) begin
                dc_acc <= dc_acc + AW'($signed(in_data));
            end
            if (ld_en) begin
                dc_mean <= DW'(dc_acc >>> n_r);
            end
        end
    end
`else
    assign dc_mean = '0;
`endif

endmodule

// File: tb/tb_gen_meter.sv
// Scoreboard bench for gen_meter: driver pushes model results, monitor checks on each done pulse.
module tb_gen_meter;

    localparam int DW = 18;
    localparam int LM = 24;

    logic          adc_clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          start;
    logic [4:0]    win_log2;
    logic          busy;
    logic          done;
    logic [DW-1:0] peak;
    logic [DW-1:0] mean_mag;
    logic [LM-1:0] zc_count;
    logic [DW-1:0] dc_mean;

    gen_meter #(.DW(DW), .LOG2_MAX(LM)) dut (
        .adc_clk  (adc_clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .start    (start),
        .win_log2 (win_log2),
        .busy     (busy),
        .done     (done),
        .peak     (peak),
        .mean_mag (mean_mag),
        .zc_count (zc_count),
        .dc_mean  (dc_mean)
    );

    always #5 adc_clk = ~adc_clk;

    int cyc = 0;
    always @(posedge adc_clk) cyc++;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        longint pk;
        longint mean;
        longint zc;
        longint dc;
        int     done_edge;
        string  tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_d = 1'b0;

    task automatic check(string name, longint act, longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp_n(int n);
        if (n == 0) return 1;
        if (n > LM) return LM;
        return n;
    endfunction

    // Reference: measurements straight from the window definition
    function automatic exp_t model(string tag, int n_req, longint s[$]);
        exp_t   e;
        int     n   = clamp_n(n_req);
        int     len = 1 << n;
        longint sum_abs = 0;
        longint sum = 0;
        longint a;
        e.pk = 0;
        e.zc = 0;
        for (int i = 0; i < len; i++) begin
            a = (s[i] < 0) ? -s[i] : s[i];
            if (a > e.pk) e.pk = a;
            sum_abs += a;
            sum     += s[i];
            if (i > 0 && s[i-1] < 0 && s[i] >= 0) e.zc++;
        end
        e.mean = sum_abs / longint'(len);
`ifdef GEN_METER_DC_EN
        e.dc = sum >>> n;
`else
        e.dc = 0;
`endif
        e.tag = tag;
        e.done_edge = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge adc_clk) begin
        if (done) begin
            if (done_d) begin
                vectors++;
                miscompares++;
                $display("FAIL done_pulse: done high for 2 cycles at edge %0d, expected 1", cyc);
            end else if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: done at edge %0d with 0 windows pending, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_peak"}, longint'(peak), mon_e.pk);
                check({mon_e.tag, "_mean"}, longint'(mean_mag), mon_e.mean);
                check({mon_e.tag, "_zc"}, longint'(zc_count), mon_e.zc);
                check({mon_e.tag, "_dc"}, longint'($signed(dc_mean)), mon_e.dc);
                check({mon_e.tag, "_done_edge"}, longint'(cyc), longint'(mon_e.done_edge));
                check({mon_e.tag, "_busy_at_done"}, longint'(busy), 0);
            end
        end
        done_d = done;
    end

    // gap_mode: 0 contiguous, 1 in_valid low every other cycle, 2 random gaps
    task automatic run_window(string tag, int n_req, longint s[$], int gap_mode, bit mid_start);
        exp_t e;
        int   n_eff = clamp_n(n_req);
        int   last  = (1 << n_eff) - 1;
        int   start_edge;
        int   t;
        bit   gap;
        e = model(tag, n_req, s);
        @(negedge adc_clk);
        start    = 1'b1;
        win_log2 = 5'(n_req);
        start_edge = cyc + 1;
        @(negedge adc_clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, longint'(busy), 1);
        for (int i = 0; i < s.size(); i++) begin
            gap = (gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
            if (gap) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                @(negedge adc_clk);
            end
            in_valid = 1'b1;
            in_data  = DW'(s[i]);
            if (mid_start && i == 0) begin
                start    = 1'b1;
                win_log2 = 5'd3;
            end
            if (i == last) begin
                e.done_edge = (gap_mode == 0) ? start_edge + (1 << n_eff) + 2 : cyc + 1 + 2;
                sb.push_back(e);
            end
            @(negedge adc_clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        t = 0;
        while (sb.size() > 0 && t < 64) begin
            @(negedge adc_clk);
            t++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: %0d windows still pending, expected 0", tag, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge adc_clk);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_peak"}, longint'(peak), 0);
        check({tag, "_mean"}, longint'(mean_mag), 0);
        check({tag, "_zc"}, longint'(zc_count), 0);
        check({tag, "_dc"}, longint'($signed(dc_mean)), 0);
    endtask

    initial begin
        longint           s[$];
        logic signed [DW-1:0] r;
        int               n;
        int               mode;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        win_log2 = '0;
        repeat (3) @(negedge adc_clk);
        check_all_zero("reset");
        reset = 1'b0;

        s = {};
        for (int i = 0; i < 16; i++) s.push_back((i % 2 == 0) ? 1000 : -1000);
        run_window("square", 4, s, 0, 1'b0);

        s = {};
        for (int i = 0; i < 8; i++) s.push_back(-131072);
        run_window("negconst", 3, s, 0, 1'b0);

        s = {};
        for (int i = 0; i < 16; i++) s.push_back(i);
        run_window("ramp_gaps", 4, s, 1, 1'b0);

        s = {500, -300, 77, 88};
        run_window("clamp_midstart", 0, s, 0, 1'b1);

        // Abort a window after 5 of 16 samples
        @(negedge adc_clk);
        start    = 1'b1;
        win_log2 = 5'd4;
        @(negedge adc_clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(-20000 + i * 9000);
            @(negedge adc_clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge adc_clk);
        reset = 1'b0;
        check_all_zero("midreset");

        s = {7, 7, 7, 7};
        run_window("after_reset", 2, s, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            n    = $urandom_range(0, 5);
            mode = $urandom_range(0, 2);
            s = {};
            for (int i = 0; i < (1 << clamp_n(n)); i++) begin
                if (mode == 0) begin
                    r = DW'($urandom);
                    s.push_back(longint'(r));
                end else if (mode == 1) begin
                    s.push_back(longint'($urandom_range(0, 400)) - 200);
                end else begin
                    case ($urandom_range(0, 3))
                        0:       s.push_back(-131072);
                        1:       s.push_back(131071);
                        2:       s.push_back(-1);
                        default: s.push_back(0);
                    endcase
                end
            end
            run_window($sformatf("rand%0d", k), n, s, $urandom_range(0, 2), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
